// File: rtl/iter_shift_sub_div.sv
// Iterative radix-2 restoring divider for the RV64M DIV/REM group (word and doubleword forms).
// One quotient bit per cycle; divide-by-zero and signed overflow bypass the iteration.
module iter_shift_sub_div #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            div_valid,
    input  logic            flush,
    input  logic            div_signed,
    input  logic            divw,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            div_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int HALF = XLEN / 2;
    localparam int CW   = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvsr_q, dvsr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            neg_q_q, neg_q_d;
    logic            neg_r_q, neg_r_d;
    logic            divw_q, divw_d;

    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_val;
    logic            a_neg, b_neg, div_by_zero, overflow;
    logic [XLEN:0]   shifted, diff;
    logic [XLEN-1:0] q_fix, r_fix;

    // Word ops see only the low half, extended according to signedness.
    always_comb begin
        a_ext = dividend;
        b_ext = divisor;
        if (divw) begin
            a_ext = div_signed ? {{HALF{dividend[HALF-1]}}, dividend[HALF-1:0]}
                               : {{HALF{1'b0}}, dividend[HALF-1:0]};
            b_ext = div_signed ? {{HALF{divisor[HALF-1]}}, divisor[HALF-1:0]}
                               : {{HALF{1'b0}}, divisor[HALF-1:0]};
        end
        a_neg       = div_signed & a_ext[XLEN-1];
        b_neg       = div_signed & b_ext[XLEN-1];
        a_mag       = a_neg ? -a_ext : a_ext;
        b_mag       = b_neg ? -b_ext : b_ext;
        min_val     = divw ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
        div_by_zero = (b_ext == '0);
        overflow    = div_signed && (a_ext == min_val) && (b_ext == '1);
    end

    // 65-bit trial subtract: a clear top bit of diff means the shifted remainder covered the divisor.
    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign diff    = shifted - {1'b0, dvsr_q};

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        cnt_d   = cnt_q;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        divw_d  = divw_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (div_valid) begin
                        divw_d  = divw;
                        dvsr_d  = b_mag;
                        neg_q_d = a_neg ^ b_neg;
                        neg_r_d = a_neg;
                        if (div_by_zero || overflow) begin
                            // Final results are loaded directly; the sign fix must leave them untouched.
                            quo_d   = div_by_zero ? '1 : a_ext;
                            rem_d   = div_by_zero ? a_ext : '0;
                            neg_q_d = 1'b0;
                            neg_r_d = 1'b0;
                            state_d = DONE;
                        end else begin
                            // Word magnitudes are parked in the top half so HALF shifts consume them fully.
                            quo_d   = divw ? {a_mag[HALF-1:0], {HALF{1'b0}}} : a_mag;
                            rem_d   = '0;
                            cnt_d   = divw ? CW'(HALF) : CW'(XLEN);
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    if (!diff[XLEN]) begin
                        rem_d = diff[XLEN-1:0];
                        quo_d = {quo_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_d = shifted[XLEN-1:0];
                        quo_d = {quo_q[XLEN-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = DONE;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: datapath registers are reset too, so the post-reset state is fully defined and observable.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
            state_q <= IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            cnt_q   <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            divw_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvsr_q  <= dvsr_d;
            cnt_q   <= cnt_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
            divw_q  <= divw_d;
        end
    end

    always_comb begin
        q_fix     = neg_q_q ? -quo_q : quo_q;
        r_fix     = neg_r_q ? -rem_q : rem_q;
        div_ready = (state_q == IDLE);
        out_valid = 1'b0;
        quotient  = '0;
        remainder = '0;
        if (state_q == DONE && !flush) begin
            out_valid = 1'b1;
            quotient  = divw_q ? {{HALF{q_fix[HALF-1]}}, q_fix[HALF-1:0]} : q_fix;
            remainder = divw_q ? {{HALF{r_fix[HALF-1]}}, r_fix[HALF-1:0]} : r_fix;
        end
    end

endmodule
